// File: rtl/blink_pkg.sv
// Shared definitions for the blink speed controller: level count, widths,
// LED reset pattern and the run/pause state encoding.
package blink_pkg;
  localparam int NLEVEL  = 4;
  localparam int SPEED_W = 2;
  localparam int LED_W   = 4;

  localparam logic [LED_W-1:0] LED_RST = 4'b0001;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } blink_state_e;
endpackage

// File: rtl/blink_prescaler.sv
// Half-period prescaler: counts 0..limit-1 while enabled and pulses tick on
// the last count; clear forces the count back to 0 and wins over everything.
module blink_prescaler #(
  parameter int DIV_BASE = 25000000,
  localparam int CNT_W   = $clog2(DIV_BASE),
  localparam int LIM_W   = CNT_W + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [LIM_W-1:0] limit,
  input  logic             clear,
  input  logic             enable,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // limit itself can need one bit more than the counter (power-of-two base)
  assign tick = enable && ({1'b0, cnt_q} == (limit - LIM_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blink_speed_ctrl.sv
// Rotating one-hot LED blinker with up/down speed buttons; the optional
// pause/run toggle (BTNPS port and FSM) exists only under BLINK_PAUSE_EN.
module blink_speed_ctrl
  import blink_pkg::*;
#(
  parameter int DIV_BASE = 25000000,
  parameter int NLEVEL   = blink_pkg::NLEVEL
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTNUP,
  input  logic               BTNDN,
`ifdef BLINK_PAUSE_EN
  input  logic               BTNPS,
`endif
  output logic [LED_W-1:0]   LED,
  output logic [SPEED_W-1:0] SPEED
);

  localparam int LIM_W = $clog2(DIV_BASE) + 1;
  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(NLEVEL - 1);

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [LIM_W-1:0]   limit;
  logic               run;
  logic               tick;
  logic               up_ok, dn_ok, spd_chg;

  assign limit = LIM_W'(DIV_BASE) >> speed_q;

`ifdef BLINK_PAUSE_EN
  blink_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (BTNPS) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign run = (state_q == ST_RUN);
`else
  assign run = 1'b1;
`endif

  // Simultaneous up/down cancels; saturated requests never reach the counter
  always_comb begin
    up_ok   = BTNUP && !BTNDN && (speed_q != SPEED_MAX);
    dn_ok   = BTNDN && !BTNUP && (speed_q != '0);
    spd_chg = up_ok || dn_ok;
    speed_d = speed_q;
    if (up_ok) begin
      speed_d = speed_q + SPEED_W'(1);
    end else if (dn_ok) begin
      speed_d = speed_q - SPEED_W'(1);
    end
    led_d = led_q;
    if (tick) begin
      led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      speed_q <= '0;
      led_q   <= LED_RST;
    end else begin
      speed_q <= speed_d;
      led_q   <= led_d;
    end
  end

  blink_prescaler #(
    .DIV_BASE(DIV_BASE)
  ) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .limit  (limit),
    .clear  (spd_chg),
    .enable (run),
    .tick   (tick)
  );

  assign LED   = led_q;
  assign SPEED = speed_q;

endmodule

// File: tb/tb_blink_speed_ctrl.sv
// Bench for blink_speed_ctrl at DIV_BASE=16: directed timing scenarios plus
// random button traffic, all checked against a cycle-level reference model.
module tb_blink_speed_ctrl;
  localparam int DIV = 16;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       BTNUP = 1'b0;
  logic       BTNDN = 1'b0;
  logic       BTNPS = 1'b0;
  logic [3:0] LED;
  logic [1:0] SPEED;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  blink_speed_ctrl #(
    .DIV_BASE(DIV),
    .NLEVEL  (4)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .BTNUP(BTNUP),
    .BTNDN(BTNDN),
`ifdef BLINK_PAUSE_EN
    .BTNPS(BTNPS),
`endif
    .LED  (LED),
    .SPEED(SPEED)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: level L blinks with half-period DIV/2^L cycles; the model
  // tracks cycles elapsed in the current half-period and the lit LED index.
  int m_speed = 0;
  int m_elapsed = 0;
  int m_idx = 0;
  bit m_run = 1'b1;

  always @(posedge CLK) begin
    int  period;
    bit  fire, want_up, want_dn;
    if (RST) begin
      m_speed = 0; m_elapsed = 0; m_idx = 0; m_run = 1'b1;
    end else begin
      period  = DIV / (1 << m_speed);
      fire    = m_run && (m_elapsed == period - 1);
      want_up = BTNUP && !BTNDN && (m_speed < 3);
      want_dn = BTNDN && !BTNUP && (m_speed > 0);
      if (fire) m_idx = (m_idx + 1) % 4;
      if (want_up || want_dn) begin
        m_speed   = m_speed + (want_up ? 1 : -1);
        m_elapsed = 0;
      end else if (fire) begin
        m_elapsed = 0;
      end else if (m_run) begin
        m_elapsed++;
      end
      if (BTNPS) m_run = !m_run;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_led", LED, 1 << m_idx);
      check("model_speed", SPEED, m_speed);
    end
  end

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // Called at a negedge; returns edges until LED changes, -1 on timeout.
  task automatic wait_chg(output int cyc);
    logic [3:0] l0;
    l0  = LED;
    cyc = 0;
    while (1) begin
      @(negedge CLK);
      cyc++;
      if (LED != l0) break;
      if (cyc >= 200) begin
        cyc = -1;
        break;
      end
    end
  endtask

  task automatic pulse(input bit u, input bit d, input bit p);
    BTNUP = u; BTNDN = d; BTNPS = p;
    @(negedge CLK);
    BTNUP = 1'b0; BTNDN = 1'b0; BTNPS = 1'b0;
  endtask

  initial begin
    int c;
    logic [3:0] l;

    repeat (3) @(negedge CLK);
    check("rst_led", LED, 1);
    check("rst_speed", SPEED, 0);
    RST = 1'b0;
    chk_en = 1'b1;

    wait_chg(c); check("first_tick", c, 16);
    check("first_led", LED, 4'b0010);
    wait_chg(c); check("period_l0", c, 16);

    // reset mid-count with LED=0100, counter=10
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_led", LED, 1);
    check("midrst_speed", SPEED, 0);
    wait_chg(c); check("midrst_tick", c, 16);

    // up request on the terminal-count cycle
    repeat (15) @(negedge CLK);
    l = LED;
    pulse(1, 0, 0);
    check("up_on_tick_rot", LED, rotl(l));
    check("up_on_tick_spd", SPEED, 1);
    wait_chg(c); check("period_l1", c, 8);

    pulse(1, 0, 0);
    check("speed_2", SPEED, 2);
    wait_chg(c); check("period_l2", c, 4);
    pulse(1, 0, 0);
    check("speed_3", SPEED, 3);
    wait_chg(c); check("period_l3", c, 2);
    wait_chg(c);
    pulse(1, 0, 0);
    check("up_sat_spd", SPEED, 3);
    wait_chg(c); check("up_sat_phase", c, 1);

    repeat (3) pulse(0, 1, 0);
    check("down_to_0", SPEED, 0);
    wait_chg(c);
    pulse(0, 1, 0);
    check("dn_sat_spd", SPEED, 0);
    wait_chg(c); check("dn_sat_phase", c, 15);

    pulse(1, 0, 0);
    wait_chg(c);
    pulse(1, 1, 0);
    check("both_spd", SPEED, 1);
    wait_chg(c); check("both_phase", c, 7);

`ifdef BLINK_PAUSE_EN
    pulse(0, 1, 0);
    wait_chg(c);
    repeat (4) @(negedge CLK);
    pulse(0, 0, 1);
    l = LED;
    repeat (100) @(negedge CLK);
    check("pause_hold", LED, l);
    pulse(0, 0, 1);
    wait_chg(c); check("resume_tick", c, 11);
`endif

    repeat (3000) begin
      BTNUP = ($urandom_range(0, 19) == 0);
      BTNDN = ($urandom_range(0, 19) == 0);
`ifdef BLINK_PAUSE_EN
      BTNPS = ($urandom_range(0, 39) == 0);
`endif
      RST   = ($urandom_range(0, 499) == 0);
      @(negedge CLK);
    end
    BTNUP = 1'b0; BTNDN = 1'b0; BTNPS = 1'b0; RST = 1'b0;
    repeat (5) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blink_speed_ctrl.md
BLINK_SPEED_CTRL -- requirements
Module: blink_speed_ctrl

Interface
REQ-001 Parameter DIV_BASE, default 25000000, half-period in CLK cycles at speed level 0 (100 MHz CLK); must be divisible by 8 and at least 8.
REQ-002 Parameter NLEVEL, default 4, number of speed levels; fixed at 4 in this revision.
REQ-003 CLK  input  1  system clock, 100 MHz.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 BTNUP  input  1  single-cycle pulse from the upstream debouncer; requests a faster blink.
REQ-006 BTNDN  input  1  single-cycle pulse from the upstream debouncer; requests a slower blink.
REQ-007 BTNPS  input  1  single-cycle pause/run toggle pulse; the port exists only when BLINK_PAUSE_EN is defined.
REQ-008 LED  output  4  one-hot rotating LED pattern, registered.
REQ-009 SPEED  output  2  current speed level, 0 = slowest, registered.

Function
REQ-010 The half-period limit SHALL be DIV_BASE >> SPEED, giving limits of DIV_BASE, /2, /4 and /8.
REQ-011 The prescaler counter SHALL count 0..limit-1; tick is asserted combinationally when counter == limit-1 and the block is in RUN; the counter SHALL wrap to 0 on tick.
REQ-012 On a tick cycle, LED SHALL rotate left by one at the next edge (0001->0010->0100->1000->0001).
REQ-013 BTNUP alone SHALL increment SPEED at the next edge, saturating at 3; at 3 it is ignored.
REQ-014 BTNDN alone SHALL decrement SPEED at the next edge, saturating at 0; at 0 it is ignored.
REQ-015 BTNUP and BTNDN asserted in the same cycle SHALL leave SPEED unchanged and SHALL NOT restart the counter.
REQ-016 An accepted SPEED change SHALL clear the counter to 0 at the same edge; the LED pattern is held, and the first tick at the new speed follows new-limit cycles later.
REQ-017 A speed request that coincides with a tick SHALL take the speed change; the rotate still occurs at that edge.
REQ-018 An ignored request (saturated) SHALL NOT disturb the counter.
REQ-019 Counter width SHALL be clog2(DIV_BASE); no overflow is permitted for any level.

Reset
REQ-020 When RST is high at a CLK edge: SPEED=0, counter=0, LED=4'b0001, state=RUN; all inputs are ignored in that cycle.
REQ-021 Reset mid-count SHALL discard the partial period; the first tick after release occurs DIV_BASE cycles later.

Configuration
REQ-022 Macro BLINK_PAUSE_EN defined: a two-state FSM {RUN, PAUSE}; BTNPS toggles the state at the next edge; in PAUSE the counter and LED hold and no tick is asserted; SPEED changes are still accepted in PAUSE and clear the counter; RUN resumes counting from the held value.
REQ-023 Macro BLINK_PAUSE_EN undefined: BTNPS is absent, the state is permanently RUN, and there is no FSM logic.

Structure
REQ-024 Shared package blink_pkg SHALL hold NLEVEL, SPEED_W=2, LED_W=4, the LED reset pattern, and the run/pause state enum.
REQ-025 One sub-module, blink_prescaler (limit input, clear input, enable input, tick output), SHALL implement REQ-011/016/019; level, LED and FSM logic stay in the top module.

Verification (DIV_BASE=16 for simulation)
REQ-026 Release reset, no buttons -> LED=0001, SPEED=0; first LED change to 0010 is 16 cycles after release; rotation period is 16 cycles.
REQ-027 Three BTNUP pulses 40 cycles apart -> SPEED goes 1,2,3; half-period becomes 8,4,2; a fourth BTNUP leaves SPEED=3 and the tick spacing undisturbed.
REQ-028 BTNDN at SPEED=0 -> no change; BTNUP and BTNDN in the same cycle at SPEED=1 -> SPEED stays 1 and the tick phase is unchanged.
REQ-029 BTNUP issued on the cycle where counter=15 at SPEED=0 -> LED rotates at that edge, SPEED=1, next rotate 8 cycles later.
REQ-030 RST pulsed with counter=10 and LED=0100 -> LED=0001, SPEED=0, next rotate 16 cycles after release.
REQ-031 (BLINK_PAUSE_EN) BTNPS at counter=5 -> LED frozen for 100 cycles; second BTNPS -> rotate occurs 11 cycles after the resume edge.
